// File: rtl/ysyx_24100029_ifu_if.sv
// Instruction-memory read channel between the IFU (master) and the memory side (slave).
interface ysyx_24100029_ifu_if;
  logic        imem_arvalid;
  logic [31:0] imem_araddr;
  logic        imem_arready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_rresp;
  logic        imem_rready;

  modport master (
    output imem_arvalid, imem_araddr, imem_rready,
    input  imem_arready, imem_rvalid, imem_rdata, imem_rresp
  );

  modport slave (
    input  imem_arvalid, imem_araddr, imem_rready,
    output imem_arready, imem_rvalid, imem_rdata, imem_rresp
  );
endinterface

// File: rtl/ysyx_24100029_ifu.sv
// Instruction fetch unit: REQ -> WAIT -> HOLD fetch loop with redirect/flush handling.
// Define YSYX_24100029_IFU_PERF_EN to add the fetch_cnt / stall_cnt performance counters.
module ysyx_24100029_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  input  logic                 pipe_stop,
  ysyx_24100029_ifu_if.master  imem,
  output logic [31:0]          inst,
  output logic [31:0]          pc,
  output logic                 access_fault,
  input  logic                 ready_next,
  output logic                 valid_next
`ifdef YSYX_24100029_IFU_PERF_EN
  ,
  output logic [31:0]          fetch_cnt,
  output logic [31:0]          stall_cnt
`endif
);

  // state  | meaning
  // S_REQ  | issue (or hold) the read address for fetch_pc
  // S_WAIT | address accepted, waiting for the read response
  // S_HOLD | instruction presented to decode, waiting for ready_next
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  state_e      state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] flush_pc_q;
  logic [31:0] inst_q;
  logic [31:0] pc_q;
  logic        flush_q;
  logic        armed_q;
  logic        fault_q;
  logic        valid_q;

  logic        ar_valid;
  logic        ar_fire;
  logic        resp_err;

  // armed_q keeps an un-accepted request on the bus; a fresh request yields to a redirect.
  assign ar_valid = (state_q == S_REQ) && (armed_q || (!pipe_stop && !redirect_valid));
  assign ar_fire  = ar_valid && imem.imem_arready;
  assign resp_err = (imem.imem_rresp != 2'b00);

  assign imem.imem_arvalid = ar_valid;
  assign imem.imem_araddr  = fetch_pc_q;
  assign imem.imem_rready  = (state_q == S_WAIT);

  assign inst         = inst_q;
  assign pc           = pc_q;
  assign access_fault = fault_q;
  assign valid_next   = valid_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      flush_pc_q <= 32'h0;
      flush_q    <= 1'b0;
      armed_q    <= 1'b0;
      inst_q     <= 32'h0;
      pc_q       <= 32'h0;
      fault_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (ar_fire) begin
            state_q <= S_WAIT;
            armed_q <= 1'b0;
            flush_q <= flush_q || redirect_valid;
            if (redirect_valid) flush_pc_q <= redirect_pc;
          end else if (ar_valid) begin
            armed_q <= 1'b1;
            if (redirect_valid) begin
              flush_q    <= 1'b1;
              flush_pc_q <= redirect_pc;
            end
          end else if (redirect_valid) begin
            fetch_pc_q <= redirect_pc;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            flush_q    <= 1'b1;
            flush_pc_q <= redirect_pc;
          end
          if (imem.imem_rvalid) begin
            if (flush_q || redirect_valid) begin
              // Stale response: drop it and restart from the newest redirect target.
              state_q    <= S_REQ;
              flush_q    <= 1'b0;
              fetch_pc_q <= redirect_valid ? redirect_pc : flush_pc_q;
            end else begin
              state_q <= S_HOLD;
              valid_q <= 1'b1;
              inst_q  <= resp_err ? 32'h0 : imem.imem_rdata;
              pc_q    <= fetch_pc_q;
              fault_q <= resp_err;
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid || ready_next) begin
            state_q    <= S_REQ;
            valid_q    <= 1'b0;
            fetch_pc_q <= redirect_valid ? redirect_pc : pc_q + 32'd4;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

`ifdef YSYX_24100029_IFU_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      if (state_q == S_HOLD && ready_next) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (state_q == S_WAIT || (state_q == S_HOLD && !ready_next))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_24100029_ifu.sv
// Bench for ysyx_24100029_ifu: random memory/decode/redirect traffic checked every cycle
// against a transaction-level model, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_ysyx_24100029_ifu;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        pipe_stop;
  logic        ready_next;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        access_fault;
  logic        valid_next;
`ifdef YSYX_24100029_IFU_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  ysyx_24100029_ifu_if imem ();

  ysyx_24100029_ifu #(.RESET_PC(RST_PC)) dut (
    .clock(clock), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pipe_stop(pipe_stop), .imem(imem), .inst(inst), .pc(pc), .access_fault(access_fault),
    .ready_next(ready_next), .valid_next(valid_next)
`ifdef YSYX_24100029_IFU_PERF_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int k_ar, k_rv, k_rn, k_ps, k_rd;

  // Transaction-level model: what address must be requested next, what is in flight, what is held.
  logic [31:0] m_exp_addr, m_held_addr, m_inf_addr, m_h_pc, m_h_inst;
  logic        m_held, m_issued_stale, m_inflight, m_inf_stale, m_holding, m_h_fault;
  logic [31:0] m_fetch, m_stall;
  logic        mem_pend;
  logic [31:0] mem_addr;
  logic [31:0] hs_q[$];
  int          hs_cyc[$];
  int          vn_cyc[$];
  logic [31:0] h_pc_q[$];
  logic [31:0] h_inst_q[$];
  logic        h_fault_q[$];

  function automatic logic [31:0] mem_data(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic mem_fault(logic [31:0] a);
    return (a == 32'h8000_0010) || (a[7:2] == 6'h2b);
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
  endfunction

  always @(negedge clock) begin
    logic        arv, arr, rv, stale_now;
    logic [31:0] cur;
    cyc++;
    if (reset !== 1'b1) begin
      m_exp_addr = RST_PC; m_held = 1'b0; m_issued_stale = 1'b0;
      m_inflight = 1'b0; m_inf_stale = 1'b0; m_holding = 1'b0;
      m_fetch = 32'h0; m_stall = 32'h0; mem_pend = 1'b0;
    end else begin
      arv = imem.imem_arvalid;
      arr = imem.imem_arready;
      rv  = imem.imem_rvalid;
      chk("rready", imem.imem_rready, m_inflight);
      chk("valid_next", valid_next, m_holding);
      if (m_holding) begin
        chk("pc", pc, m_h_pc);
        chk("inst", inst, m_h_inst);
        chk("access_fault", access_fault, m_h_fault);
      end
`ifdef YSYX_24100029_IFU_PERF_EN
      chk("fetch_cnt", fetch_cnt, m_fetch);
      chk("stall_cnt", stall_cnt, m_stall);
`endif
      if (m_held) begin
        chk("arvalid_stable", arv, 1'b1);
        chk("araddr_stable", imem.imem_araddr, m_held_addr);
      end else if (m_inflight || m_holding) begin
        chk("arvalid_busy", arv, 1'b0);
      end else begin
        if (!redirect_valid) chk("arvalid_issue", arv, !pipe_stop);
        if (arv) chk("araddr_issue", imem.imem_araddr, m_exp_addr);
      end

      if (m_holding && ready_next) m_fetch++;
      if (m_inflight || (m_holding && !ready_next)) m_stall++;

      cur = m_held ? m_held_addr : m_exp_addr;
      stale_now = (m_held && m_issued_stale) || redirect_valid;

      if (m_holding && (ready_next || redirect_valid)) begin
        if (ready_next) begin
          vn_cyc.push_back(cyc);
          h_pc_q.push_back(pc);
          h_inst_q.push_back(inst);
          h_fault_q.push_back(access_fault);
        end
        m_holding = 1'b0;
        if (!redirect_valid) m_exp_addr = m_h_pc + 32'd4;
      end

      if (m_inflight && rv) begin
        m_inflight = 1'b0;
        mem_pend = 1'b0;
        if (!(m_inf_stale || redirect_valid)) begin
          m_holding = 1'b1;
          m_h_pc    = m_inf_addr;
          m_h_fault = mem_fault(m_inf_addr);
          m_h_inst  = m_h_fault ? 32'h0 : mem_data(m_inf_addr);
        end
      end else if (m_inflight && redirect_valid) begin
        m_inf_stale = 1'b1;
      end

      if (arv && arr) begin
        m_inflight = 1'b1; m_inf_addr = cur; m_inf_stale = stale_now; m_held = 1'b0;
        mem_pend = 1'b1; mem_addr = imem.imem_araddr;
        hs_q.push_back(imem.imem_araddr);
        hs_cyc.push_back(cyc);
      end else if (arv) begin
        if (!m_held) m_held_addr = cur;
        m_issued_stale = stale_now;
        m_held = 1'b1;
      end else begin
        m_held = 1'b0;
      end

      if (redirect_valid) m_exp_addr = redirect_pc;
    end
  end

  task automatic drive();
    imem.imem_arready = ($urandom_range(99) < k_ar);
    imem.imem_rvalid  = mem_pend && ($urandom_range(99) < k_rv);
    imem.imem_rdata   = mem_data(mem_addr);
    imem.imem_rresp   = mem_fault(mem_addr) ? 2'b10 : 2'b00;
    ready_next        = ($urandom_range(99) < k_rn);
    pipe_stop         = ($urandom_range(99) < k_ps);
    redirect_valid    = ($urandom_range(99) < k_rd);
    redirect_pc       = 32'h8000_0000 | ($urandom & 32'h0000_0FFC);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    drive();
  endtask

  task automatic obs();
    @(negedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok, saw;
    int          n0;
    logic [31:0] sv_pc;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; pipe_stop = 1'b0; ready_next = 1'b0;
    imem.imem_arready = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'h0; imem.imem_rresp = 2'b00;
    mem_pend = 1'b0; mem_addr = 32'h0;
    k_ar = 100; k_rv = 100; k_rn = 100; k_ps = 0; k_rd = 0;

    repeat (3) tick();
    reset = 1'b1;
    hs_q.delete(); hs_cyc.delete(); vn_cyc.delete();
    h_pc_q.delete(); h_inst_q.delete(); h_fault_q.delete();
    obs();
    chk("rst_valid_next", valid_next, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_fault", access_fault, 1'b0);
    chk("rst_rready", imem.imem_rready, 1'b0);
    chk("rst_arvalid", imem.imem_arvalid, 1'b1);
    chk("rst_araddr", imem.imem_araddr, 32'h8000_0000);

    // Zero-wait memory, decode always ready.
    repeat (21) begin tick(); obs(); end
    chk("zw_hs_count", hs_q.size() >= 5, 1'b1);
    chk("zw_hold_count", h_pc_q.size() >= 5, 1'b1);
    if (hs_q.size() >= 5 && h_pc_q.size() >= 5) begin
      chk("zw_addr0", hs_q[0], 32'h8000_0000);
      chk("zw_addr1", hs_q[1], 32'h8000_0004);
      chk("zw_addr2", hs_q[2], 32'h8000_0008);
      chk("zw_ar_gap0", hs_cyc[1] - hs_cyc[0], 3);
      chk("zw_ar_gap1", hs_cyc[2] - hs_cyc[1], 3);
      chk("zw_vn_gap", vn_cyc[1] - vn_cyc[0], 3);
      chk("zw_pc0", h_pc_q[0], 32'h8000_0000);
      chk("zw_inst0", h_inst_q[0], 32'hDEAD_3EEF);
      chk("zw_fault0", h_fault_q[0], 1'b0);
      chk("fault_pc", h_pc_q[4], 32'h8000_0010);
      chk("fault_inst", h_inst_q[4], 32'h0);
      chk("fault_flag", h_fault_q[4], 1'b1);
    end

    // Decode stalls in HOLD for 5 cycles.
    k_rn = 0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); obs(); if (valid_next) ok = 1'b1; end
    chk("hold_reached", ok, 1'b1);
    sv_pc = m_h_pc;
    repeat (5) begin
      tick(); obs();
      chk("hold_valid", valid_next, 1'b1);
      chk("hold_pc", pc, sv_pc);
      chk("hold_no_ar", imem.imem_arvalid, 1'b0);
    end
    n0 = hs_q.size();
    k_rn = 100;
    for (int i = 0; i < 10 && hs_q.size() == n0; i++) begin tick(); obs(); end
    chk("resume_seen", hs_q.size() > n0, 1'b1);
    if (hs_q.size() > n0) chk("resume_addr", hs_q[n0], sv_pc + 32'd4);

    // Redirect while waiting for the response.
    k_rv = 0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); obs(); if (imem.imem_rready) ok = 1'b1; end
    chk("wait_reached", ok, 1'b1);
    n0 = hs_q.size();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    obs();
    k_rv = 100;
    saw = 1'b0;
    for (int i = 0; i < 10 && hs_q.size() == n0; i++) begin
      tick(); obs();
      if (valid_next) saw = 1'b1;
    end
    chk("flush_no_valid", saw, 1'b0);
    chk("flush_seen", hs_q.size() > n0, 1'b1);
    if (hs_q.size() > n0) chk("flush_addr", hs_q[n0], 32'h8000_0100);

    // arready withheld while pipe_stop toggles; then pipe_stop blocks new requests.
    k_ar = 0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); obs(); if (imem.imem_arvalid) ok = 1'b1; end
    chk("ar_wait_reached", ok, 1'b1);
    sv_pc = m_held_addr;
    for (int i = 0; i < 3; i++) begin
      tick();
      pipe_stop = (i % 2 == 0);
      obs();
      chk("ar_hold_valid", imem.imem_arvalid, 1'b1);
      chk("ar_hold_addr", imem.imem_araddr, sv_pc);
    end
    k_ar = 100;
    k_ps = 100;
    repeat (8) begin tick(); obs(); end
    n0 = hs_q.size();
    repeat (5) begin tick(); obs(); chk("stop_no_ar", imem.imem_arvalid, 1'b0); end
    chk("stop_no_hs", hs_q.size(), n0);
    k_ps = 0;

    // Reset asserted mid-transaction.
    k_rv = 0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); obs(); if (imem.imem_rready) ok = 1'b1; end
    chk("rst_wait_reached", ok, 1'b1);
    tick();
    reset = 1'b0;
    k_rv = 100;
    tick();
    reset = 1'b1;
    obs();
    chk("mid_rst_valid", valid_next, 1'b0);
    chk("mid_rst_inst", inst, 32'h0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_fault", access_fault, 1'b0);
    chk("mid_rst_rready", imem.imem_rready, 1'b0);
    chk("mid_rst_arvalid", imem.imem_arvalid, 1'b1);
    chk("mid_rst_araddr", imem.imem_araddr, 32'h8000_0000);
`ifdef YSYX_24100029_IFU_PERF_EN
    chk("mid_rst_fetch_cnt", fetch_cnt, 32'h0);
`endif

    // Random traffic with moderate redirect rate, then heavy redirects.
    k_ar = 60; k_rv = 50; k_rn = 60; k_ps = 20; k_rd = 6;
    n0 = hs_q.size();
    repeat (3000) tick();
    obs();
    chk("random_progress", hs_q.size() > n0 + 100, 1'b1);
    k_rd = 30;
    repeat (600) tick();
    k_rd = 0;
    repeat (20) tick();
    obs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
